// File: rtl/eu_icon_read_arbiter.sv
// eu_icon_read_arbiter
// Round-robin arbiter that shares one execution unit's interconnect read port
// between NUM_REQ requesters. Each transaction is arbitrated, held on the EU
// port until success, and then answered with a single done pulse.
// Optional feature macro: EU_ICON_ARB_TIMEOUT_EN. When it is defined, a
// request is abandoned after MAX_WAIT cycles without success, and a fail
// pulse is produced.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among req_valid_i
// ISSUE  | request held on the EU port until eu_rsuccess_i
// DONE   | done pulse to the granted requester, rr_ptr advances
// FAIL   | fail pulse to the granted requester (timeout build only)

module eu_icon_read_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic [NUM_REQ-1:0]        req_fail_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic [ADDR_W-1:0]         eu_raddr_o,
  output logic                      eu_rvalid_o,
  input  logic                      eu_rsuccess_i,
  input  logic [DATA_W-1:0]         eu_rdata_i,
  output logic                      busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE, ST_FAIL} state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]    gnt_idx, gnt_idx_d;
  logic [ADDR_W-1:0]   gnt_addr, gnt_addr_d;
  logic [7:0]          wait_cnt, wait_cnt_d;
  logic [DATA_W-1:0]   data_d;
  logic [ADDR_W-1:0]   raddr_d;
  logic                rvalid_d, busy_d;
  logic [NUM_REQ-1:0]  done_d, fail_d;
  logic [IDX_W-1:0]    pick, next_ptr;
  logic                found;

`ifndef EU_ICON_ARB_TIMEOUT_EN
  // The wait limit only matters when the timeout is compiled in.
  logic unused_wait_last;
  assign unused_wait_last = ^WAIT_LAST;
`endif

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    gnt_idx_d  = gnt_idx;
    gnt_addr_d = gnt_addr;
    wait_cnt_d = wait_cnt;
    data_d     = req_data_o;
    found      = 1'b0;
    pick       = '0;
    sum        = '0;
    cand       = '0;
    next_ptr   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state)
      ST_IDLE: begin
        if (found) begin
          gnt_idx_d  = pick;
          gnt_addr_d = req_addr_i[int'(pick)*ADDR_W +: ADDR_W];
          wait_cnt_d = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (eu_rsuccess_i) begin
          data_d  = eu_rdata_i;
          state_d = ST_DONE;
        end else begin
`ifdef EU_ICON_ARB_TIMEOUT_EN
          if (wait_cnt == WAIT_LAST) state_d = ST_FAIL;
`endif
          if (wait_cnt != 8'hFF) wait_cnt_d = wait_cnt + 8'd1;
        end
      end
      ST_DONE, ST_FAIL: begin
        rr_ptr_d = next_ptr;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    rvalid_d = (state_d == ST_ISSUE);
    raddr_d  = rvalid_d ? gnt_addr_d : '0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = '0;
    fail_d   = '0;
    if (state_d == ST_DONE) done_d[gnt_idx_d] = 1'b1;
`ifdef EU_ICON_ARB_TIMEOUT_EN
    if (state_d == ST_FAIL) fail_d[gnt_idx_d] = 1'b1;
`endif
  end

  // State, bookkeeping and registered outputs; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      gnt_addr    <= '0;
      wait_cnt    <= '0;
      req_done_o  <= '0;
      req_fail_o  <= '0;
      req_data_o  <= '0;
      eu_raddr_o  <= '0;
      eu_rvalid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      gnt_idx     <= gnt_idx_d;
      gnt_addr    <= gnt_addr_d;
      wait_cnt    <= wait_cnt_d;
      req_done_o  <= done_d;
      req_fail_o  <= fail_d;
      req_data_o  <= data_d;
      eu_raddr_o  <= raddr_d;
      eu_rvalid_o <= rvalid_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_eu_icon_read_arbiter.sv
// Bench for eu_icon_read_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_eu_icon_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;
`ifdef EU_ICON_ARB_TIMEOUT_EN
  localparam int MAXD = MW - 1;
`else
  localparam int MAXD = 6;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_done, req_fail;
  logic [DW-1:0] req_data;
  logic [AW-1:0] eu_raddr;
  logic          eu_rvalid;
  logic          eu_rsuccess = 1'b0;
  logic [DW-1:0] eu_rdata = '0;
  logic          busy;

  eu_icon_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_done_o(req_done), .req_fail_o(req_fail), .req_data_o(req_data),
    .eu_raddr_o(eu_raddr), .eu_rvalid_o(eu_rvalid), .eu_rsuccess_i(eu_rsuccess),
    .eu_rdata_i(eu_rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      int r;
      r = (ptr + i) % N;
      if (v[r]) return r;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0]  mask;
    int            exp_idx;
    int            delay;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [7];
  logic [AW-1:0] addr_of [N];

  initial begin
    int  done_idx [5];
    int  done_cyc [5];
    int  ndone;
    bit  ok;
    int  m_phase, m_ptr, m_g, m_delay, m_stall;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [N-1:0]    sv;
    logic [N*AW-1:0] sa;
    logic            ss;
    logic [DW-1:0]   sd;

    addr_of[0] = 8'h5C; addr_of[1] = 8'h21; addr_of[2] = 8'h3A; addr_of[3] = 8'h97;
    vecs[0] = '{4'b0100, 2, 1, 32'hDEADBEEF};
    vecs[1] = '{4'b1111, 3, 0, 32'h11111111};
    vecs[2] = '{4'b0110, 1, 2, 32'h22222222};
    vecs[3] = '{4'b0011, 0, 0, 32'h33333333};
    vecs[4] = '{4'b1000, 3, 5, 32'h44444444};
    vecs[5] = '{4'b0001, 0, 0, 32'h55555555};
    vecs[6] = '{4'b1101, 2, 3, 32'h66666666};
    for (int r = 0; r < N; r++) req_addr[r*AW +: AW] = addr_of[r];

    // Reset state
    step(); step();
    chk("rst_done", req_done, 0);
    chk("rst_fail", req_fail, 0);
    chk("rst_data", req_data, 0);
    chk("rst_raddr", eu_raddr, 0);
    chk("rst_rvalid", eu_rvalid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      req_valid = vecs[v].mask;
      step();
      chk("vec_rvalid", eu_rvalid, 1);
      chk("vec_raddr", eu_raddr, addr_of[vecs[v].exp_idx]);
      chk("vec_busy", busy, 1);
      ok = 1'b1;
      for (int k = 0; k <= vecs[v].delay; k++) begin
        if (eu_rvalid !== 1'b1 || eu_raddr !== addr_of[vecs[v].exp_idx] || req_done !== '0) ok = 1'b0;
        eu_rsuccess = (k == vecs[v].delay);
        eu_rdata    = vecs[v].data;
        step();
      end
      chk("vec_hold", ok, 1);
      chk("vec_done", req_done, 1 << vecs[v].exp_idx);
      chk("vec_data", req_data, vecs[v].data);
      chk("vec_rvalid_off", eu_rvalid, 0);
      chk("vec_fail", req_fail, 0);
      eu_rsuccess = 1'b0;
      req_valid   = '0;
      step();
      chk("vec_done_clr", req_done, 0);
      chk("vec_idle", busy, 0);
    end
    // rr_ptr is now 3

`ifdef EU_ICON_ARB_TIMEOUT_EN
    req_valid = 4'b0100;
    step();
    ok = 1'b1;
    for (int k = 0; k < MW; k++) begin
      if (eu_rvalid !== 1'b1 || eu_raddr !== addr_of[2] || req_fail !== '0) ok = 1'b0;
      step();
    end
    chk("to_hold", ok, 1);
    chk("to_fail", req_fail, 4'b0100);
    chk("to_done", req_done, 0);
    chk("to_rvalid", eu_rvalid, 0);
    req_valid = '0;
    step();
    chk("to_fail_clr", req_fail, 0);
    req_valid = 4'b1111;
    step();
    chk("to_ptr_adv", eu_raddr, addr_of[3]);
    for (int k = 0; k < MW; k++) begin
      eu_rsuccess = (k == MW - 1);
      eu_rdata    = 32'hCAFE0001;
      step();
    end
    chk("to_last_done", req_done, 4'b1000);
    chk("to_last_fail", req_fail, 0);
    eu_rsuccess = 1'b0;
    req_valid   = '0;
    step();
`else
    req_valid = 4'b0100;
    step();
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (eu_rvalid !== 1'b1 || eu_raddr !== addr_of[2] || req_fail !== '0 || req_done !== '0) ok = 1'b0;
      step();
    end
    chk("noto_stay_issue", ok, 1);
    eu_rsuccess = 1'b1;
    eu_rdata    = 32'hCAFE0002;
    step();
    chk("noto_done", req_done, 4'b0100);
    eu_rsuccess = 1'b0;
    req_valid   = '0;
    step();
`endif

    // Round-robin with all requesters active and immediate success
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid   = 4'b1111;
    eu_rsuccess = 1'b1;
    eu_rdata    = 32'h0BADF00D;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (req_done != '0) begin
        if (ndone < 5) begin
          done_cyc[ndone] = c;
          done_idx[ndone] = -1;
          for (int r = 0; r < N; r++) if (req_done[r]) done_idx[ndone] = r;
        end
        ndone++;
      end
    end
    chk("rr_count", ndone, 5);
    for (int i = 0; i < 5 && i < ndone; i++) begin
      chk("rr_order", done_idx[i], i % N);
      if (i > 0) chk("rr_spacing", done_cyc[i] - done_cyc[i-1], 3);
    end

    // Reset in ISSUE: requester 1 in flight, rr_ptr = 1
    eu_rsuccess = 1'b0;
    chk("rst_pre_issue", eu_rvalid, 1);
    reset = 1'b1;
    step();
    chk("rst_mid_done", req_done, 0);
    chk("rst_mid_rvalid", eu_rvalid, 0);
    chk("rst_mid_raddr", eu_raddr, 0);
    chk("rst_mid_data", req_data, 0);
    chk("rst_mid_busy", busy, 0);
    reset     = 1'b0;
    req_valid = '0;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (req_done !== '0 || req_fail !== '0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_pulse", ok, 1);
    req_valid = 4'b1111;
    step();
    chk("rst_ptr_zero", eu_raddr, addr_of[0]);
    eu_rsuccess = 1'b1;
    eu_rdata    = 32'h12345678;
    req_valid   = '0;
    step();
    chk("rst_after_done", req_done, 4'b0001);
    eu_rsuccess = 1'b0;
    step();

    // Requester 1 drops its request during ISSUE
    req_valid = 4'b0010;
    step();
    chk("drop_raddr", eu_raddr, addr_of[1]);
    req_valid = '0;
    step(); step();
    chk("drop_still_issue", eu_rvalid, 1);
    eu_rsuccess = 1'b1;
    eu_rdata    = 32'h87654321;
    step();
    chk("drop_done", req_done, 4'b0010);
    chk("drop_data", req_data, 32'h87654321);
    eu_rsuccess = 1'b0;
    step();

    // Random traffic against the reference model
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_phase = 0; m_ptr = 0; m_g = 0; m_delay = 0; m_stall = 0;
    m_addr = '0; m_data = '0;
    for (int c = 0; c < 2000; c++) begin
      sv = req_valid; sa = req_addr; ss = eu_rsuccess; sd = eu_rdata;
      step();
      case (m_phase)
        0: if (sv != '0) begin
             m_g     = rr_pick(sv, m_ptr);
             m_addr  = sa[m_g*AW +: AW];
             m_phase = 1;
             m_stall = 0;
             m_delay = $urandom_range(0, MAXD);
           end
        1: if (ss) begin
             m_data  = sd;
             m_phase = 2;
           end
        default: begin
          m_ptr   = (m_g + 1) % N;
          m_phase = 0;
        end
      endcase
      chk("rnd_rvalid", eu_rvalid, m_phase == 1);
      if (m_phase == 1) chk("rnd_raddr", eu_raddr, m_addr);
      chk("rnd_done", req_done, (m_phase == 2) ? (1 << m_g) : 0);
      if (m_phase == 2) chk("rnd_data", req_data, m_data);
      chk("rnd_fail", req_fail, 0);
      chk("rnd_busy", busy, m_phase != 0);
      for (int r = 0; r < N; r++) begin
        if (req_done[r] || req_fail[r]) req_valid[r] = 1'b0;
        else if (!req_valid[r] && $urandom_range(0, 3) == 0) begin
          req_valid[r] = 1'b1;
          req_addr[r*AW +: AW] = {6'($urandom), 2'(r)};
        end
      end
      eu_rdata    = $urandom;
      eu_rsuccess = (m_phase == 1) && (m_stall == m_delay);
      if (m_phase == 1) m_stall++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
